// File: rtl/hgame_pkg.sv
// rtl/hgame_pkg.sv - shared state encoding and popcount helper for hgame_multi
package hgame_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        RESULT = 2'd2
    } state_t;

    localparam int MAX_N = 8;

    // Counts the set bits of x[w-1:0]; callers zero-extend narrower vectors.
    function automatic logic [3:0] popcount(input logic [MAX_N-1:0] x, input int w);
        logic [3:0] cnt;
        cnt = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (i < w) begin
                cnt = cnt + 4'(x[i]);
            end
        end
        return cnt;
    endfunction

endpackage

// File: rtl/hgame_score.sv
// rtl/hgame_score.sv - N saturating per-player win counters
module hgame_score #(
    parameter int N  = 3,
    parameter int SW = 8
) (
    input  logic            i_clk,
    input  logic            i_clr,
    input  logic [N-1:0]    i_inc,
    output logic [N*SW-1:0] o_score
);

    logic [N*SW-1:0] r_score;

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_score <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (i_inc[i] && (r_score[i*SW +: SW] != {SW{1'b1}})) begin
                    r_score[i*SW +: SW] <= r_score[i*SW +: SW] + SW'(1);
                end
            end
        end
    end

    assign o_score = r_score;

endmodule

// File: rtl/hgame_multi.sv
// rtl/hgame_multi.sv - multi-player reaction game judge with hold, timeout and scoring
module hgame_multi
    import hgame_pkg::*;
#(
    parameter int N       = 3,
    parameter int HOLD    = 1,
    parameter int TIMEOUT = 0,
    parameter int SW      = 8
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [N-1:0]    PRESS,
    output logic [N-1:0]    DISP,
    output logic [N-1:0]    WINNER,
    output logic            WIN_VALID,
    output logic            DRAW,
    output logic            TMO,
    output logic [N*SW-1:0] SCORE
);

    if (N < 2 || N > MAX_N) begin : g_bad_n
        $error("hgame_multi: N must be in 2..8");
    end
    if (HOLD < 1 || HOLD > 255) begin : g_bad_hold
        $error("hgame_multi: HOLD must be in 1..255");
    end
    if (TIMEOUT < 0) begin : g_bad_timeout
        $error("hgame_multi: TIMEOUT must be non-negative");
    end
    if (SW < 1) begin : g_bad_sw
        $error("hgame_multi: SW must be at least 1");
    end

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [7:0]       HOLD_LAST = 8'(HOLD - 1);

    state_t             r_state, w_state_n;
    logic [N-1:0]       r_f, w_f_n;
    logic [CNT_W-1:0]   r_cnt, w_cnt_n;
    logic [7:0]         r_hold, w_hold_n;
    logic [N-1:0]       r_disp, w_disp_n;
    logic [N-1:0]       r_winner, w_winner_n;
    logic               r_valid, w_valid_n;
    logic               r_draw, w_draw_n;
    logic               r_tmo, w_tmo_n;
    logic [N-1:0]       w_inc;
    logic [N-1:0]       w_new;
    logic [MAX_N-1:0]   w_press_x, w_new_x;
    logic [3:0]         w_pc_press, w_pc_new;

    assign w_new = PRESS & ~r_f;

    always_comb begin
        w_press_x = '0;
        w_new_x   = '0;
        w_press_x[N-1:0] = PRESS;
        w_new_x[N-1:0]   = w_new;
    end

    assign w_pc_press = popcount(w_press_x, N);
    assign w_pc_new   = popcount(w_new_x, N);

    always_comb begin
        w_state_n  = r_state;
        w_f_n      = r_f;
        w_cnt_n    = r_cnt;
        w_hold_n   = r_hold;
        w_disp_n   = r_disp;
        w_winner_n = r_winner;
        w_valid_n  = 1'b0;
        w_draw_n   = r_draw;
        w_tmo_n    = r_tmo;
        w_inc      = '0;
        case (r_state)
            IDLE: begin
                w_winner_n = '0;
                w_draw_n   = 1'b0;
                w_tmo_n    = 1'b0;
                if (PRESS != '0) begin
                    w_disp_n = PRESS;
                end
                if (w_pc_press == 4'(N)) begin
                    w_state_n  = RESULT;
                    w_hold_n   = HOLD_LAST;
                    w_winner_n = '1;
                    w_draw_n   = 1'b1;
                    w_valid_n  = 1'b1;
                end else if (w_pc_press == 4'(N - 1)) begin
                    w_state_n  = RESULT;
                    w_hold_n   = HOLD_LAST;
                    w_winner_n = ~PRESS;
                    w_valid_n  = 1'b1;
                    w_inc      = ~PRESS;
                end else if (w_pc_press != 4'd0) begin
                    w_state_n = WAIT;
                    w_f_n     = PRESS;
                    w_cnt_n   = '0;
                end
            end
            WAIT: begin
                if (PRESS != '0) begin
                    w_disp_n = PRESS;
                end
                if (w_new != '0) begin
                    // A lone late presser joins the first group; a multi-press tie loses to it.
                    w_state_n  = RESULT;
                    w_hold_n   = HOLD_LAST;
                    w_winner_n = (w_pc_new == 4'd1) ? (r_f | w_new) : r_f;
                    w_valid_n  = 1'b1;
                    w_inc      = (w_pc_new == 4'd1) ? (r_f | w_new) : r_f;
                end else if (TIMEOUT > 0) begin
                    if (r_cnt == TMO_LAST) begin
                        w_state_n  = RESULT;
                        w_hold_n   = HOLD_LAST;
                        w_winner_n = r_f;
                        w_tmo_n    = 1'b1;
                        w_valid_n  = 1'b1;
                        w_inc      = r_f;
                    end else begin
                        w_cnt_n = r_cnt + CNT_W'(1);
                    end
                end
            end
            RESULT: begin
                if (r_hold == 8'd0) begin
                    w_state_n  = IDLE;
                    w_disp_n   = '0;
                    w_winner_n = '0;
                    w_draw_n   = 1'b0;
                    w_tmo_n    = 1'b0;
                end else begin
                    w_hold_n = r_hold - 8'd1;
                end
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= IDLE;
            r_f      <= '0;
            r_cnt    <= '0;
            r_hold   <= '0;
            r_disp   <= '0;
            r_winner <= '0;
            r_valid  <= 1'b0;
            r_draw   <= 1'b0;
            r_tmo    <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_f      <= w_f_n;
            r_cnt    <= w_cnt_n;
            r_hold   <= w_hold_n;
            r_disp   <= w_disp_n;
            r_winner <= w_winner_n;
            r_valid  <= w_valid_n;
            r_draw   <= w_draw_n;
            r_tmo    <= w_tmo_n;
        end
    end

    hgame_score #(
        .N  (N),
        .SW (SW)
    ) u_score (
        .i_clk   (CLK),
        .i_clr   (RST),
        .i_inc   (w_inc),
        .o_score (SCORE)
    );

    assign DISP      = r_disp;
    assign WINNER    = r_winner;
    assign WIN_VALID = r_valid;
    assign DRAW      = r_draw;
    assign TMO       = r_tmo;

endmodule

// File: tb/tb_hgame_multi.sv
// tb/tb_hgame_multi.sv - scoreboard bench for hgame_multi (two parameter sets)
module tb_hgame_multi;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b;
    logic [2:0]  press_a;
    logic [3:0]  press_b;
    logic [2:0]  disp_a, win_a;
    logic [3:0]  disp_b, win_b;
    logic        wv_a, wv_b, draw_a, draw_b, tmo_a, tmo_b;
    logic [5:0]  score_a;
    logic [31:0] score_b;

    hgame_multi #(.N(3), .HOLD(3), .TIMEOUT(5), .SW(2)) u_dut_a (
        .CLK(clk), .RST(rst_a), .PRESS(press_a), .DISP(disp_a), .WINNER(win_a),
        .WIN_VALID(wv_a), .DRAW(draw_a), .TMO(tmo_a), .SCORE(score_a)
    );

    hgame_multi #(.N(4), .HOLD(1), .TIMEOUT(0), .SW(8)) u_dut_b (
        .CLK(clk), .RST(rst_b), .PRESS(press_b), .DISP(disp_b), .WINNER(win_b),
        .WIN_VALID(wv_b), .DRAW(draw_b), .TMO(tmo_b), .SCORE(score_b)
    );

    typedef struct {
        int          d;
        logic [7:0]  winner;
        logic        draw;
        logic        tmo;
        logic [31:0] score;
    } exp_t;

    exp_t sb[$];
    int   mdl[2][8];
    int   checks = 0;
    int   errors = 0;
    int   n_steps;
    int   s5_exp[5] = '{1, 2, 3, 3, 3};

    function automatic logic [31:0] o_win(int d);   return (d == 0) ? 32'(win_a)   : 32'(win_b);   endfunction
    function automatic logic [31:0] o_disp(int d);  return (d == 0) ? 32'(disp_a)  : 32'(disp_b);  endfunction
    function automatic logic [31:0] o_wv(int d);    return (d == 0) ? 32'(wv_a)    : 32'(wv_b);    endfunction
    function automatic logic [31:0] o_draw(int d);  return (d == 0) ? 32'(draw_a)  : 32'(draw_b);  endfunction
    function automatic logic [31:0] o_tmo(int d);   return (d == 0) ? 32'(tmo_a)   : 32'(tmo_b);   endfunction
    function automatic logic [31:0] o_score(int d); return (d == 0) ? 32'(score_a) : score_b;      endfunction

    function automatic logic [31:0] mdl_pack(int d);
        logic [31:0] p;
        p = '0;
        if (d == 0) begin
            for (int i = 0; i < 3; i++) p[i*2 +: 2] = mdl[0][i][1:0];
        end else begin
            for (int i = 0; i < 4; i++) p[i*8 +: 8] = mdl[1][i][7:0];
        end
        return p;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setp(input int d, input logic [7:0] v);
        if (d == 0) press_a = v[2:0];
        else        press_b = v[3:0];
    endtask

    task automatic push_res(input int d, input logic [7:0] w, input logic dr, input logic tm);
        exp_t e;
        int   smax;
        smax = (d == 0) ? 3 : 255;
        if (!dr) begin
            for (int i = 0; i < 8; i++) begin
                if (w[i] && mdl[d][i] < smax) mdl[d][i]++;
            end
        end
        e.d = d; e.winner = w; e.draw = dr; e.tmo = tm; e.score = mdl_pack(d);
        sb.push_back(e);
    endtask

    task automatic wait_res(input int d, input int budget, output int n);
        exp_t e;
        n = 0;
        while (o_wv(d) != 1 && n < budget) begin
            step();
            n++;
        end
        if (o_wv(d) != 1) begin
            chk("result_timeout", o_wv(d), 1);
            if (sb.size() > 0) void'(sb.pop_front());
        end else if (sb.size() == 0) begin
            chk("spurious_result", o_wv(d), 0);
        end else begin
            e = sb.pop_front();
            chk($sformatf("d%0d_winner", d), o_win(d),   32'(e.winner));
            chk($sformatf("d%0d_draw", d),   o_draw(d),  32'(e.draw));
            chk($sformatf("d%0d_tmo", d),    o_tmo(d),   32'(e.tmo));
            chk($sformatf("d%0d_score", d),  o_score(d), e.score);
        end
    endtask

    task automatic hold_out(input int d, input int hold, input logic [7:0] w);
        for (int k = 1; k < hold; k++) begin
            step();
            chk("hold_winner", o_win(d), 32'(w));
            chk("hold_wv", o_wv(d), 0);
        end
        step();
        chk("exit_winner", o_win(d), 0);
        chk("exit_disp", o_disp(d), 0);
        chk("exit_draw", o_draw(d), 0);
        chk("exit_tmo", o_tmo(d), 0);
    endtask

    task automatic reset_dut(input int d);
        if (d == 0) rst_a = 1'b1;
        else        rst_b = 1'b1;
        step();
        chk("rst_disp", o_disp(d), 0);
        chk("rst_winner", o_win(d), 0);
        chk("rst_wv", o_wv(d), 0);
        chk("rst_draw", o_draw(d), 0);
        chk("rst_tmo", o_tmo(d), 0);
        chk("rst_score", o_score(d), 0);
        for (int i = 0; i < 8; i++) mdl[d][i] = 0;
        if (d == 0) rst_a = 1'b0;
        else        rst_b = 1'b0;
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; press_a = '0; press_b = '0;
        for (int i = 0; i < 8; i++) begin mdl[0][i] = 0; mdl[1][i] = 0; end
        step(); step();
        reset_dut(0);
        reset_dut(1);

        // Scenario 1: two of three press, odd one out wins
        setp(0, 8'b011); push_res(0, 8'b100, 0, 0);
        step(); wait_res(0, 1, n_steps);
        setp(0, 8'b000); hold_out(0, 3, 8'b100);

        // Scenario 2: multi-press late group loses, then single late presser joins
        setp(0, 8'b100); step();
        chk("s2_disp_wait", o_disp(0), 32'b100);
        setp(0, 8'b000); step(); step();
        chk("s2_no_result", o_wv(0), 0);
        setp(0, 8'b011); push_res(0, 8'b100, 0, 0);
        step(); wait_res(0, 1, n_steps);
        setp(0, 8'b000); hold_out(0, 3, 8'b100);
        setp(0, 8'b100); step();
        setp(0, 8'b001); push_res(0, 8'b101, 0, 0);
        step(); wait_res(0, 1, n_steps);
        setp(0, 8'b000); hold_out(0, 3, 8'b101);

        // Scenario 4: timeout after 5 quiet cycles, held for 3
        setp(0, 8'b010); step();
        setp(0, 8'b000); push_res(0, 8'b010, 0, 1);
        wait_res(0, 12, n_steps);
        chk("s4_timeout_cycles", n_steps, 5);
        chk("s4_disp_held", o_disp(0), 32'b010);
        hold_out(0, 3, 8'b010);

        // Scenario 5: held press re-evaluated each round, SW=2 saturation
        reset_dut(0);
        setp(0, 8'b110);
        for (int r = 0; r < 5; r++) begin
            push_res(0, 8'b001, 0, 0);
            step(); wait_res(0, 8, n_steps);
            chk("s5_score0", 32'(score_a[1:0]), s5_exp[r]);
        end
        setp(0, 8'b000); hold_out(0, 3, 8'b001);

        // Scenario 6: reset in WAIT, in RESULT, and alongside all-ones press
        setp(0, 8'b100); step();
        setp(0, 8'b000); reset_dut(0);
        setp(0, 8'b011); push_res(0, 8'b100, 0, 0);
        step(); wait_res(0, 1, n_steps);
        setp(0, 8'b000); reset_dut(0);
        step();
        chk("s6_idle_after_rst", o_win(0), 0);
        setp(0, 8'b111); reset_dut(0);
        setp(0, 8'b000); step();
        chk("s6_no_result_wv", o_wv(0), 0);
        chk("s6_no_result_draw", o_draw(0), 0);

        // Scenario 3 (N=4): draw leaves scores, then 0011 + 0100
        setp(1, 8'b1111); push_res(1, 8'b1111, 1, 0);
        step(); wait_res(1, 1, n_steps);
        setp(1, 8'b0000); hold_out(1, 1, 8'b1111);
        setp(1, 8'b0011); step();
        chk("s3_disp", o_disp(1), 32'b0011);
        setp(1, 8'b0100); push_res(1, 8'b0111, 0, 0);
        step(); wait_res(1, 1, n_steps);
        setp(1, 8'b0000); hold_out(1, 1, 8'b0111);

        // TIMEOUT=0 waits indefinitely
        setp(1, 8'b1000); step();
        setp(1, 8'b0000);
        for (int i = 0; i < 20; i++) step();
        chk("b_no_timeout_wv", o_wv(1), 0);
        chk("b_no_timeout_disp", o_disp(1), 32'b1000);
        setp(1, 8'b0001); push_res(1, 8'b1001, 0, 0);
        step(); wait_res(1, 1, n_steps);
        setp(1, 8'b0000); hold_out(1, 1, 8'b1001);

        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hgame_multi.md
HGAME_MULTI -- requirements
Module: hgame_multi

Interface
REQ-001 The block SHALL have parameter N, default 3, meaning the player count (legal range 2..8).
REQ-002 The block SHALL have parameter HOLD, default 1, meaning the number of cycles a result is held (legal range 1..255).
REQ-003 The block SHALL have parameter TIMEOUT, default 0, meaning the WAIT timeout in cycles, where 0 disables the timeout.
REQ-004 The block SHALL have parameter SW, default 8, meaning the per-player score width in bits.
REQ-005 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-006 RST  input  1  reset, synchronous and active-high.
REQ-007 PRESS  input  N  player press vector, one bit per player, sampled every edge.
REQ-008 DISP  output  N  registered copy of the most recent nonzero press vector in the current round.
REQ-009 WINNER  output  N  registered winner set, nonzero only while in RESULT.
REQ-010 WIN_VALID  output  1  high for exactly the first RESULT cycle of each round.
REQ-011 DRAW  output  1  high throughout RESULT when the round ended as a draw.
REQ-012 TMO  output  1  high throughout RESULT when the round ended by timeout.
REQ-013 SCORE  output  N*SW  flattened per-player win counters; player i occupies bits [i*SW +: SW].

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, WAIT and RESULT; p(x) denotes the popcount of x.
REQ-015 In IDLE with PRESS==0, the FSM SHALL stay in IDLE and SHALL leave all outputs unchanged except WINNER, DRAW and TMO, which are 0.
REQ-016 In IDLE with p(PRESS)==N, the FSM SHALL go to RESULT with WINNER=all ones and DRAW=1.
REQ-017 In IDLE with p(PRESS)==N-1, the FSM SHALL go to RESULT with WINNER=~PRESS, the odd player out.
REQ-018 In IDLE with 0<p(PRESS)<N-1, the FSM SHALL latch F=PRESS and go to WAIT.
REQ-019 In WAIT, the FSM SHALL form NEW=PRESS&~F and act on it as follows:
- NEW==0: stay in WAIT.
- p(NEW)==1: go to RESULT with WINNER=F|NEW.
- p(NEW)>=2: go to RESULT with WINNER=F.
REQ-020 If TIMEOUT>0, WAIT SHALL count cycles with NEW==0; on reaching TIMEOUT, the FSM SHALL go to RESULT with WINNER=F and TMO=1.
REQ-021 The WAIT cycle counter SHALL be cleared on every entry to WAIT.
REQ-022 In IDLE and WAIT, DISP SHALL load PRESS on any edge where PRESS is nonzero, and SHALL hold otherwise.
REQ-023 The decision latency SHALL be one cycle: WINNER, WIN_VALID, DRAW and TMO are visible the cycle after the deciding PRESS is sampled.
REQ-024 RESULT SHALL last exactly HOLD cycles, during which PRESS is ignored.
REQ-025 On leaving RESULT, the FSM SHALL go to IDLE and clear DISP, WINNER, DRAW and TMO to 0.
REQ-026 On the WIN_VALID cycle of every non-draw result, each player i with WINNER[i]=1 SHALL have SCORE_i incremented by 1.
REQ-027 SCORE_i SHALL saturate at 2^SW-1.
REQ-028 A draw SHALL NOT change any score.
REQ-029 The same press held across rounds SHALL be re-evaluated in IDLE after RESULT; no edge detection is applied.

Reset
REQ-030 RST SHALL take priority over every FSM action in the same cycle.
REQ-031 While RST is high, the block SHALL force state=IDLE, clear F and the WAIT counter, and drive DISP, WINNER, WIN_VALID, DRAW, TMO and all SCORE fields to 0.
REQ-032 RST asserted in WAIT or RESULT SHALL abort the round without any score update.

Structure
REQ-033 Package hgame_pkg SHALL hold the state enum (IDLE, WAIT, RESULT) and a popcount function parameterised on width.
REQ-034 Sub-module hgame_score SHALL implement the N saturating SW-bit counters, taking an increment mask and a clear input.
REQ-035 Parameter legality SHALL be checked at elaboration.

Verification
REQ-036 Scenario 1: N=3; PRESS=3'b011 from IDLE -> next cycle WINNER=3'b100, WIN_VALID=1, SCORE_2=1.
REQ-037 Scenario 2: N=3; PRESS=3'b100, then 3'b000 for 2 cycles, then 3'b011 -> WINNER=3'b100 (p(NEW)=2); then 3'b100, 3'b001 -> WINNER=3'b101.
REQ-038 Scenario 3: N=4; PRESS=4'b1111 -> DRAW=1, WINNER=4'b1111, no score change; then PRESS=4'b0011, then 4'b0100 -> WINNER=4'b0111.
REQ-039 Scenario 4: TIMEOUT=5; PRESS=3'b010 then idle -> RESULT entered 5 cycles later with WINNER=3'b010 and TMO=1; with HOLD=3, WINNER is held for 3 cycles and then returns to 0.
REQ-040 Scenario 5: SW=2; player 0 wins 5 rounds -> SCORE_0 reads 1, 2, 3, 3, 3.
REQ-041 Scenario 6: RST asserted in WAIT and in RESULT -> next cycle IDLE with all outputs 0; RST together with PRESS=all ones -> no RESULT is entered.
